data_sram_bridge: RTL
=====================

// Module: data_sram_bridge
// PURPOSE
//  Sits between the CPU data-memory port (data_sram_en/wen/addr/wdata/rdata)
//  and a variable-latency memory with a two-phase addr_ok/data_ok handshake.
//  Captures each CPU access, sequences it onto the memory side and stalls the
//  pipeline until the data returns.
//  Adds a per-access timeout so a hung memory cannot lock the core.
// PARAMETERS
//  TIMEOUT   256           cycles in REQ+WAIT before an access is aborted (>=2)
//  ERR_DATA  32'hDEADBEEF  cpu_rdata returned on an aborted read
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  cpu_en       in   1   CPU access request (sampled only in IDLE/DONE)
//  cpu_wen      in   4   byte write enables; 4'b0000 = read
//  cpu_addr     in   32  byte address
//  cpu_wdata    in   32  store data
//  cpu_rdata    out  32  load data, valid in DONE
//  cpu_stall    out  1   high while an access is outstanding
//  mem_req      out  1   request valid to memory
//  mem_wr       out  1   1 = write, 0 = read
//  mem_wstrb    out  4   byte strobes (copy of captured cpu_wen)
//  mem_addr     out  32  captured address, unmodified
//  mem_wdata    out  32  captured store data
//  mem_addr_ok  in   1   request accepted this cycle (valid only while mem_req)
//  mem_data_ok  in   1   read data / write ack returned this cycle
//  mem_rdata    in   32  read data, valid with mem_data_ok
//  bus_err      out  1   sticky: some access timed out
// BEHAVIOUR
//  - FSM: IDLE, REQ, WAIT, DONE. Reset -> IDLE; cpu_rdata=0, bus_err=0, timer=0,
//    captured wen/addr/wdata=0.
//  - IDLE/DONE with cpu_en=1: capture wen/addr/wdata; next state REQ.
//    IDLE/DONE with cpu_en=0: next state IDLE.
//  - REQ: mem_req=1 with captured fields held stable.
//    addr_ok=1 & data_ok=0 -> WAIT. addr_ok=1 & data_ok=1 same cycle -> DONE.
//  - WAIT: mem_req=0. data_ok=1 -> DONE.
//  - Data capture: on a read's data_ok, cpu_rdata <= mem_rdata.
//    Write completions leave cpu_rdata unchanged.
//  - cpu_stall = (state==REQ)|(state==WAIT), combinational from state only.
//  - Access latency: minimum 2 cycles (capture, then REQ with addr_ok+data_ok).
//    CPU sees data in DONE.
//  - cpu_rdata holds its value until the next completion; only DONE is valid.
//  - Timer: cleared on entering REQ; increments each cycle in REQ/WAIT.
//    timer==TIMEOUT-1 with no data_ok -> DONE, bus_err<=1,
//    cpu_rdata<=ERR_DATA (reads only).
//  - data_ok in IDLE/REQ-before-addr_ok/DONE is ignored (stale or reset-orphaned).
//  - cpu_en while stalled is ignored; the CPU holds its request.
//  - Reset mid-access: immediately IDLE, mem_req drops next cycle.
//    Outstanding transaction abandoned, not retried.
//  - bus_err clears only on reset.
//  - Back-to-back: cpu_en in DONE starts the next access with no IDLE bubble.
// TESTING
//  - Read, mem replies addr_ok+data_ok in the REQ cycle, rdata=32'h12345678
//    -> stall exactly 1 cycle; cpu_rdata=32'h12345678 in DONE.
//  - Write wen=4'b0011, addr=0x1004, wdata=0xAABBCCDD; addr_ok after 3 cycles,
//    data_ok 2 later -> mem_wr=1, mem_wstrb=0011, fields stable throughout REQ;
//    stall 6 cycles; cpu_rdata unchanged.
//  - Memory never answers a read -> after 256 stall cycles DONE,
//    cpu_rdata=0xDEADBEEF, bus_err=1 and stays 1 over later good accesses.
//  - Reset asserted during WAIT, then data_ok pulse after reset
//    -> state IDLE, pulse ignored, cpu_rdata=0, no stall.
//  - Two back-to-back reads (cpu_en held through DONE), data 0x1 then 0x2
//    -> second REQ directly follows DONE; cpu_rdata 0x1 then 0x2.

Source files
------------

// File: rtl/data_sram_bridge.sv
// Bridges the CPU data-memory port onto a variable-latency addr_ok/data_ok memory,
// stalling the CPU per access and aborting accesses that exceed TIMEOUT cycles.
module data_sram_bridge #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic accept;
    logic complete;
    logic abort;
    logic is_read;
    logic busy;

    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && cpu_en;
    assign is_read  = (wen_q == 4'b0000);
    // data_ok counts only once the request has been accepted; stray pulses are dropped.
    assign complete = ((state_q == S_REQ) && mem_addr_ok && mem_data_ok)
                    || ((state_q == S_WAIT) && mem_data_ok);
    assign abort    = busy && !complete && (timer_q == TW'(TIMEOUT - 1));

    // State register plus captured request/response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            wen_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting every combinational output first prevents latch inference
        // on paths a case arm does not assign.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: state_d = cpu_en ? S_REQ : S_IDLE;
            S_REQ: begin
                if (complete || abort) state_d = S_DONE;
                else if (mem_addr_ok)  state_d = S_WAIT;
            end
            S_WAIT: begin
                if (complete || abort) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture, timer, read data and sticky error.
    always_comb begin
        timer_d   = timer_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        if (accept) begin
            timer_d = '0;
            wen_d   = cpu_wen;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
        end else if (busy) begin
            timer_d = timer_q + 1'b1;
        end
        if (complete && is_read) rdata_d = mem_rdata;
        if (abort) begin
            bus_err_d = 1'b1;
            if (is_read) rdata_d = ERR_DATA;
        end
    end

    // Outputs decoded from state and captured fields only.
    always_comb begin
        cpu_stall = busy;
        mem_req   = (state_q == S_REQ);
        mem_wr    = !is_read;
    end

    assign mem_wstrb = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign bus_err   = bus_err_q;

endmodule
